// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b line/word types and the prefetcher state encoding
package lc3b_types;
  typedef logic [127:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;
  typedef enum logic [1:0] {IDLE, PASS, FETCH, READY} l2_pf_state_t;
endpackage

// File: rtl/pf_line_buffer.sv
// rtl/pf_line_buffer.sv - prefetched line storage, last-offered line record and line hit compare
module pf_line_buffer
  import lc3b_types::*;
#(
  parameter int line_size      = 128,
  parameter int log_line_bytes = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_addr,
  input  lc3b_word               new_addr,
  input  logic                   load_data,
  input  logic [line_size-1:0]   new_data,
  input  logic                   commit,
  input  logic [15-log_line_bytes:0] probe_line,
  output lc3b_word               fetch_addr,
  output logic [line_size-1:0]   buf_data,
  output lc3b_word               last_addr,
  output logic                   last_valid,
  output logic                   hit
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr <= '0;
      buf_data   <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else begin
      if (load_addr) fetch_addr <= new_addr;
      if (load_data) buf_data <= new_data;
      // remembering the offered line suppresses an immediate duplicate prefetch
      if (commit) begin
        last_addr  <= fetch_addr;
        last_valid <= 1'b1;
      end
    end
  end

  assign hit = (probe_line == fetch_addr[15:log_line_bytes]);
endmodule

// File: rtl/l2_prefetcher.sv
// rtl/l2_prefetcher.sv - next-line prefetcher and L2/physical-memory arbiter (L2 has priority)
module l2_prefetcher
  import lc3b_types::*;
#(
  parameter int line_size      = 128,
  parameter int log_line_bytes = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l2_mem_read,
  input  logic                 l2_mem_resp,
  input  lc3b_word             l2_mem_address,
  input  logic                 l2_pmem_read,
  input  logic                 l2_pmem_write,
  input  lc3b_word             l2_pmem_address,
  input  logic [line_size-1:0] l2_pmem_wdata,
  output logic                 l2_pmem_resp,
  output logic [line_size-1:0] l2_pmem_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output lc3b_word             pmem_address,
  output logic [line_size-1:0] pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [line_size-1:0] pmem_rdata,
  output logic                 prefetch_ready,
  output logic                 prefetch_busy,
  output lc3b_word             prefetch_address,
  output logic [line_size-1:0] prefetch_wdata,
  input  logic                 no_prefetch,
  input  logic                 done_prefetch
);
  localparam int line_bits = 16 - log_line_bytes;

  l2_pf_state_t         state;
  logic                 pending;
  lc3b_word             cand;
  logic                 req_read, req_write;
  lc3b_word             req_addr;
  logic [line_size-1:0] req_wdata;

  logic                 l2_req, handshake, rd_hit, cand_ok;
  logic                 load_addr, load_data, commit, hit, last_valid;
  logic [line_bits:0]   cand_sum;
  lc3b_word             cand_next, fetch_addr, last_addr;
  logic [line_size-1:0] buf_data;
  logic                 unused_offset_bits;

  assign l2_req    = l2_pmem_read | l2_pmem_write;
  assign handshake = done_prefetch | no_prefetch;

  // carry out of the line increment means the next line would wrap to 0x0000
  assign cand_sum  = {1'b0, l2_mem_address[15:log_line_bytes]} + {{line_bits{1'b0}}, 1'b1};
  assign cand_next = {cand_sum[line_bits-1:0], {log_line_bytes{1'b0}}};
  assign cand_ok   = l2_mem_read & l2_mem_resp & ~cand_sum[line_bits]
                   & ~(last_valid & (cand_next == last_addr));
  assign unused_offset_bits = ^l2_mem_address[log_line_bytes-1:0];

  assign rd_hit    = (state == READY) & ~handshake & l2_pmem_read & ~l2_pmem_write & hit;
  assign load_addr = (state == IDLE) & ~l2_req & pending;
  assign load_data = (state == FETCH) & pmem_resp;
  assign commit    = (state == READY) & (handshake | rd_hit);

  pf_line_buffer #(.line_size(line_size), .log_line_bytes(log_line_bytes)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load_addr  (load_addr),
    .new_addr   (cand),
    .load_data  (load_data),
    .new_data   (pmem_rdata),
    .commit     (commit),
    .probe_line (l2_pmem_address[15:log_line_bytes]),
    .fetch_addr (fetch_addr),
    .buf_data   (buf_data),
    .last_addr  (last_addr),
    .last_valid (last_valid),
    .hit        (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      cand      <= '0;
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      if (cand_ok) begin
        cand    <= cand_next;
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (l2_req) begin
            state     <= PASS;
            req_read  <= l2_pmem_read;
            req_write <= l2_pmem_write;
            req_addr  <= l2_pmem_address;
            req_wdata <= l2_pmem_wdata;
          end else if (pending) begin
            state   <= FETCH;
            pending <= cand_ok;
          end
        end
        PASS:  if (pmem_resp) state <= IDLE;
        FETCH: if (pmem_resp) state <= READY;
        READY: begin
          // handshake beats a coincident L2 request, which is then served from IDLE
          if (handshake || rd_hit) begin
            state <= IDLE;
          end else if (l2_req) begin
            state     <= PASS;
            req_read  <= l2_pmem_read;
            req_write <= l2_pmem_write;
            req_addr  <= l2_pmem_address;
            req_wdata <= l2_pmem_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    l2_pmem_resp     = 1'b0;
    l2_pmem_rdata    = '0;
    prefetch_ready   = 1'b0;
    prefetch_busy    = 1'b0;
    prefetch_address = '0;
    prefetch_wdata   = '0;
    case (state)
      PASS: begin
        pmem_read     = req_read;
        pmem_write    = req_write;
        pmem_address  = req_addr;
        pmem_wdata    = req_wdata;
        l2_pmem_resp  = pmem_resp;
        l2_pmem_rdata = pmem_rdata;
      end
      FETCH: begin
        pmem_read     = 1'b1;
        pmem_address  = fetch_addr;
        prefetch_busy = 1'b1;
      end
      READY: begin
        prefetch_ready   = 1'b1;
        prefetch_busy    = 1'b1;
        prefetch_address = fetch_addr;
        prefetch_wdata   = buf_data;
        if (rd_hit) begin
          l2_pmem_resp  = 1'b1;
          l2_pmem_rdata = buf_data;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l2_prefetcher.sv
// tb/tb_l2_prefetcher.sv - vector table plus pmem scoreboard bench for l2_prefetcher
module tb_l2_prefetcher;
  import lc3b_types::*;

  localparam int mem_lat = 2;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      l2_mem_read = 1'b0, l2_mem_resp = 1'b0;
  lc3b_word  l2_mem_address = '0;
  logic      l2_pmem_read = 1'b0, l2_pmem_write = 1'b0;
  lc3b_word  l2_pmem_address = '0;
  lc3b_block l2_pmem_wdata = '0;
  logic      l2_pmem_resp;
  lc3b_block l2_pmem_rdata;
  logic      pmem_read, pmem_write;
  lc3b_word  pmem_address;
  lc3b_block pmem_wdata;
  logic      pmem_resp = 1'b0;
  lc3b_block pmem_rdata = '0;
  logic      prefetch_ready, prefetch_busy;
  lc3b_word  prefetch_address;
  lc3b_block prefetch_wdata;
  logic      no_prefetch = 1'b0, done_prefetch = 1'b0;

  l2_prefetcher #(.line_size(128), .log_line_bytes(4)) dut (
    .clk(clk), .reset(reset),
    .l2_mem_read(l2_mem_read), .l2_mem_resp(l2_mem_resp), .l2_mem_address(l2_mem_address),
    .l2_pmem_read(l2_pmem_read), .l2_pmem_write(l2_pmem_write),
    .l2_pmem_address(l2_pmem_address), .l2_pmem_wdata(l2_pmem_wdata),
    .l2_pmem_resp(l2_pmem_resp), .l2_pmem_rdata(l2_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .prefetch_ready(prefetch_ready), .prefetch_busy(prefetch_busy),
    .prefetch_address(prefetch_address), .prefetch_wdata(prefetch_wdata),
    .no_prefetch(no_prefetch), .done_prefetch(done_prefetch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    bit        wr;
    lc3b_word  addr;
    lc3b_block wdata;
  } pmem_txn_t;
  pmem_txn_t exp_q[$];

  typedef struct {
    lc3b_word dem;
    bit       exp_fetch;
    lc3b_word exp_addr;
    bit       use_no;
  } vec_t;
  vec_t vt[9];

  function automatic lc3b_block pat(input lc3b_word a);
    lc3b_block r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = a ^ lc3b_word'(16'h1111 * i) ^ 16'hA5C3;
    return r;
  endfunction

  task automatic chk(input string name, input lc3b_block act, input lc3b_block exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // physical memory: answers each request mem_lat cycles after it appears
  int mem_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = pat(pmem_address);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL pmem_unexpected: got wr=%0b addr=%h expected no access", pmem_write, pmem_address);
        end else begin
          pmem_txn_t e;
          e = exp_q.pop_front();
          if (e.wr !== pmem_write || e.wr === pmem_read || e.addr !== pmem_address ||
              (e.wr && e.wdata !== pmem_wdata)) begin
            n_mis++;
            $display("FAIL pmem_txn: got wr=%0b addr=%h wdata=%h expected wr=%0b addr=%h wdata=%h",
                     pmem_write, pmem_address, pmem_wdata, e.wr, e.addr, e.wdata);
          end
        end
      end
    end
  end

  task automatic demand(input lc3b_word a);
    @(negedge clk);
    l2_mem_read = 1'b1; l2_mem_resp = 1'b1; l2_mem_address = a;
    @(negedge clk);
    l2_mem_read = 1'b0; l2_mem_resp = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (prefetch_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic handshake(input bit use_no);
    if (use_no) no_prefetch = 1'b1; else done_prefetch = 1'b1;
    @(negedge clk);
    no_prefetch = 1'b0; done_prefetch = 1'b0;
    #2;
    chk("ready_after_handshake", 128'(prefetch_ready), 128'(0));
  endtask

  task automatic quiet(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #2;
      if (prefetch_busy || pmem_read || pmem_write) seen = 1'b1;
    end
  endtask

  task automatic l2_access(input bit wr, input lc3b_word a, input lc3b_block wd,
                           output lc3b_block rd, output int waited, output bit ok);
    l2_pmem_read = !wr; l2_pmem_write = wr; l2_pmem_address = a; l2_pmem_wdata = wd;
    waited = 0; ok = 1'b0; rd = '0;
    for (int i = 0; i < 30; i++) begin
      #2;
      if (l2_pmem_resp) begin ok = 1'b1; rd = l2_pmem_rdata; break; end
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    l2_pmem_read = 1'b0; l2_pmem_write = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pmem_read"},   128'(pmem_read), 128'(0));
    chk({tag, "_pmem_write"},  128'(pmem_write), 128'(0));
    chk({tag, "_pmem_addr"},   128'(pmem_address), 128'(0));
    chk({tag, "_pmem_wdata"},  pmem_wdata, 128'(0));
    chk({tag, "_l2_resp"},     128'(l2_pmem_resp), 128'(0));
    chk({tag, "_l2_rdata"},    l2_pmem_rdata, 128'(0));
    chk({tag, "_pf_ready"},    128'(prefetch_ready), 128'(0));
    chk({tag, "_pf_busy"},     128'(prefetch_busy), 128'(0));
    chk({tag, "_pf_addr"},     128'(prefetch_address), 128'(0));
    chk({tag, "_pf_wdata"},    prefetch_wdata, 128'(0));
  endtask

  task automatic fetch_and_offer(input lc3b_word a, input bit use_no);
    bit ok;
    wait_ready(ok);
    chk("ready_seen", 128'(ok), 128'(1));
    chk("pf_addr", 128'(prefetch_address), 128'(a));
    chk("pf_wdata", prefetch_wdata, pat(a));
    chk("pf_busy", 128'(prefetch_busy), 128'(1));
    handshake(use_no);
  endtask

  initial begin
    bit        ok, seen;
    int        waited;
    lc3b_block rd;
    lc3b_block wd;

    vt[0] = '{16'h1234, 1'b1, 16'h1240, 1'b0};
    vt[1] = '{16'h1238, 1'b0, 16'h0000, 1'b0};
    vt[2] = '{16'hFFF8, 1'b0, 16'h0000, 1'b0};
    vt[3] = '{16'h0000, 1'b1, 16'h0010, 1'b1};
    vt[4] = '{16'h000F, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{16'h1230, 1'b1, 16'h1240, 1'b0};
    vt[6] = '{16'hABCD, 1'b1, 16'hABD0, 1'b1};
    vt[7] = '{16'hFFEF, 1'b1, 16'hFFF0, 1'b0};
    vt[8] = '{16'hFFF0, 1'b0, 16'h0000, 1'b0};

    @(negedge clk); #2;
    check_idle_outputs("reset");
    reset = 1'b0;

    foreach (vt[i]) begin
      demand(vt[i].dem);
      if (vt[i].exp_fetch) begin
        exp_q.push_back('{1'b0, vt[i].exp_addr, '0});
        fetch_and_offer(vt[i].exp_addr, vt[i].use_no);
      end else begin
        quiet(8, seen);
        chk("dropped_candidate_quiet", 128'(seen), 128'(0));
      end
    end

    // L2 request and pending candidate together: pass-through first, then the fetch
    exp_q.push_back('{1'b0, 16'h2000, '0});
    exp_q.push_back('{1'b0, 16'h5010, '0});
    demand(16'h5000);
    l2_access(1'b0, 16'h2000, '0, rd, waited, ok);
    chk("pass_resp", 128'(ok), 128'(1));
    chk("pass_rdata", rd, pat(16'h2000));
    chk("pass_latency", 128'(waited), 128'(mem_lat));
    fetch_and_offer(16'h5010, 1'b0);

    // buffer hit answers in the same cycle and records the line
    exp_q.push_back('{1'b0, 16'h7010, '0});
    demand(16'h7000);
    wait_ready(ok);
    chk("hit_ready", 128'(ok), 128'(1));
    l2_access(1'b0, 16'h7016, '0, rd, waited, ok);
    chk("hit_resp", 128'(ok), 128'(1));
    chk("hit_same_cycle", 128'(waited), 128'(0));
    chk("hit_rdata", rd, pat(16'h7010));
    #2;
    chk("hit_ready_cleared", 128'(prefetch_ready), 128'(0));
    demand(16'h7008);
    quiet(8, seen);
    chk("hit_recorded_last", 128'(seen), 128'(0));

    // write in READY discards the buffer without recording it
    wd = pat(16'h3000) ^ {128{1'b1}};
    exp_q.push_back('{1'b0, 16'h8010, '0});
    demand(16'h8000);
    wait_ready(ok);
    chk("wr_ready", 128'(ok), 128'(1));
    exp_q.push_back('{1'b1, 16'h3000, wd});
    l2_access(1'b1, 16'h3000, wd, rd, waited, ok);
    chk("wr_resp", 128'(ok), 128'(1));
    chk("wr_latency", 128'(waited), 128'(mem_lat));
    #2;
    chk("wr_discard_ready", 128'(prefetch_ready), 128'(0));
    exp_q.push_back('{1'b0, 16'h8010, '0});
    demand(16'h8008);
    fetch_and_offer(16'h8010, 1'b0);

    // reset in the middle of a fetch
    demand(16'h9000);
    @(negedge clk); #2;
    chk("fetch_pmem_read", 128'(pmem_read), 128'(1));
    chk("fetch_pmem_addr", 128'(pmem_address), 128'(16'h9010));
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet(6, seen);
    chk("post_reset_quiet", 128'(seen), 128'(0));
    exp_q.push_back('{1'b0, 16'h1240, '0});
    demand(16'h1238);
    fetch_and_offer(16'h1240, 1'b0);

    quiet(4, seen);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
